// File: rtl/wshb_pkg.sv
// wshb_pkg: shared arbiter state encoding and master identifiers.
package wshb_pkg;
   typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_MIRE} state_t;
   localparam logic LAST_VGA  = 1'b0;
   localparam logic LAST_MIRE = 1'b1;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 classic/burst bundle; dat_ms flows master->slave, dat_sm slave->master.
interface wshb_if #(parameter int DATA_BYTES = 4) ();
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [31:0]             adr;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [8*DATA_BYTES-1:0] dat_sm;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    ack;
   logic                    err;
   logic                    rty;
   modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte, input dat_sm, ack, err, rty);
   modport slave  (input cyc, stb, we, adr, dat_ms, sel, cti, bte, output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin two-master Wishbone arbiter (vga, mire) in front of the SDRAM port.
// A grant is held for the whole cyc window of the owner and handed straight to a waiting master.
module wshb_arbiter
   import wshb_pkg::*;
#(
   parameter int DATA_BYTES = 4
) (
   input logic    sys_clk,
   input logic    sys_rst,
   wshb_if.slave  wshb_ifs_vga,
   wshb_if.slave  wshb_ifs_mire,
   wshb_if.master wshb_ifm_sdram
);
   state_t state_q, state_d;
   logic   last_gnt_q, last_gnt_d;
   logic   cyc_v, cyc_m, gnt_v, gnt_m;

   assign cyc_v = wshb_ifs_vga.cyc;
   assign cyc_m = wshb_ifs_mire.cyc;
   assign gnt_v = (state_q == GNT_VGA);
   assign gnt_m = (state_q == GNT_MIRE);

   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state_q    <= IDLE;
         last_gnt_q <= LAST_MIRE;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end

   // stb is deliberately ignored: only cyc opens or closes an ownership window
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE:
            state_d = (cyc_v && cyc_m) ? ((last_gnt_q == LAST_MIRE) ? GNT_VGA : GNT_MIRE) :
                      cyc_v ? GNT_VGA : cyc_m ? GNT_MIRE : IDLE;
         GNT_VGA:
            if (!cyc_v) begin
               last_gnt_d = LAST_VGA;
               state_d    = cyc_m ? GNT_MIRE : IDLE;
            end
         GNT_MIRE:
            if (!cyc_m) begin
               last_gnt_d = LAST_MIRE;
               state_d    = cyc_v ? GNT_VGA : IDLE;
            end
         default: state_d = IDLE;
      endcase
   end

   assign wshb_ifm_sdram.cyc    = gnt_v ? wshb_ifs_vga.cyc    : gnt_m ? wshb_ifs_mire.cyc    : 1'b0;
   assign wshb_ifm_sdram.stb    = gnt_v ? wshb_ifs_vga.stb    : gnt_m ? wshb_ifs_mire.stb    : 1'b0;
   assign wshb_ifm_sdram.we     = gnt_v ? wshb_ifs_vga.we     : gnt_m ? wshb_ifs_mire.we     : 1'b0;
   assign wshb_ifm_sdram.adr    = gnt_v ? wshb_ifs_vga.adr    : gnt_m ? wshb_ifs_mire.adr    : 32'h0;
   assign wshb_ifm_sdram.dat_ms = gnt_v ? wshb_ifs_vga.dat_ms : gnt_m ? wshb_ifs_mire.dat_ms : {8*DATA_BYTES{1'b0}};
   assign wshb_ifm_sdram.sel    = gnt_v ? wshb_ifs_vga.sel    : gnt_m ? wshb_ifs_mire.sel    : {DATA_BYTES{1'b0}};
   assign wshb_ifm_sdram.cti    = gnt_v ? wshb_ifs_vga.cti    : gnt_m ? wshb_ifs_mire.cti    : 3'b000;
   assign wshb_ifm_sdram.bte    = gnt_v ? wshb_ifs_vga.bte    : gnt_m ? wshb_ifs_mire.bte    : 2'b00;

   assign wshb_ifs_vga.ack  = gnt_v & wshb_ifm_sdram.ack;
   assign wshb_ifs_vga.err  = gnt_v & wshb_ifm_sdram.err;
   assign wshb_ifs_vga.rty  = gnt_v & wshb_ifm_sdram.rty;
   assign wshb_ifs_mire.ack = gnt_m & wshb_ifm_sdram.ack;
   assign wshb_ifs_mire.err = gnt_m & wshb_ifm_sdram.err;
   assign wshb_ifs_mire.rty = gnt_m & wshb_ifm_sdram.rty;

   assign wshb_ifs_vga.dat_sm  = wshb_ifm_sdram.dat_sm;
   assign wshb_ifs_mire.dat_sm = wshb_ifm_sdram.dat_sm;
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed vector table, hand-written burst/reset/err sequences and a randomized
// run against an ownership-based reference model.
module tb_wshb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   wshb_if #(.DATA_BYTES(4)) vga ();
   wshb_if #(.DATA_BYTES(4)) mire ();
   wshb_if #(.DATA_BYTES(4)) sdram ();

   wshb_arbiter #(.DATA_BYTES(4)) dut (
      .sys_clk        (clk),
      .sys_rst        (rst),
      .wshb_ifs_vga   (vga),
      .wshb_ifs_mire  (mire),
      .wshb_ifm_sdram (sdram)
   );

   typedef struct {
      logic        rst, vc, mc, ack;
      logic        e_cyc;
      logic [31:0] e_adr;
      logic        e_vack, e_mack;
   } vec_t;

   vec_t tv[16];

   function automatic vec_t mk(int r, int v, int m, int a, int c, int adr, int va, int ma);
      vec_t x;
      x.rst = r[0]; x.vc = v[0]; x.mc = m[0]; x.ack = a[0];
      x.e_cyc = c[0]; x.e_adr = adr; x.e_vack = va[0]; x.e_mack = ma[0];
      return x;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      vga.cyc = 0; vga.stb = 0; vga.we = 0; vga.adr = 0; vga.dat_ms = 0; vga.sel = 0; vga.cti = 0; vga.bte = 0;
      mire.cyc = 0; mire.stb = 0; mire.we = 0; mire.adr = 0; mire.dat_ms = 0; mire.sel = 0; mire.cti = 0; mire.bte = 0;
      sdram.ack = 0; sdram.err = 0; sdram.rty = 0; sdram.dat_sm = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic        mcyc[2], mstb[2], mwe[2];
   logic [31:0] madr[2], mdat[2];
   logic [3:0]  msel[2];
   logic [2:0]  mcti[2];
   logic [1:0]  mbte[2];
   int          own, last;

   initial begin
      clear_inputs();
      tv[0]  = mk(1, 1, 1, 1, 0, 32'h000, 0, 0);
      tv[1]  = mk(0, 1, 0, 1, 0, 32'h000, 0, 0);
      tv[2]  = mk(0, 1, 0, 1, 1, 32'h100, 1, 0);
      tv[3]  = mk(0, 0, 0, 0, 0, 32'h100, 0, 0);
      tv[4]  = mk(0, 1, 1, 1, 0, 32'h000, 0, 0);
      tv[5]  = mk(0, 1, 1, 1, 1, 32'h200, 0, 1);
      tv[6]  = mk(0, 1, 0, 0, 0, 32'h200, 0, 0);
      tv[7]  = mk(0, 1, 1, 1, 1, 32'h100, 1, 0);
      tv[8]  = mk(0, 0, 1, 0, 0, 32'h100, 0, 0);
      tv[9]  = mk(0, 0, 1, 1, 1, 32'h200, 0, 1);
      tv[10] = mk(0, 0, 0, 0, 0, 32'h200, 0, 0);
      tv[11] = mk(0, 0, 0, 0, 0, 32'h000, 0, 0);
      tv[12] = mk(0, 1, 1, 1, 0, 32'h000, 0, 0);
      tv[13] = mk(1, 1, 1, 1, 0, 32'h000, 0, 0);
      tv[14] = mk(0, 1, 1, 0, 0, 32'h000, 0, 0);
      tv[15] = mk(0, 0, 1, 1, 0, 32'h100, 1, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst = tv[i].rst;
         vga.cyc = tv[i].vc; vga.stb = tv[i].vc; vga.adr = 32'h100;
         mire.cyc = tv[i].mc; mire.stb = tv[i].mc; mire.adr = 32'h200;
         sdram.ack = tv[i].ack;
         #1;
         check($sformatf("vec%0d_cyc", i), sdram.cyc, tv[i].e_cyc);
         check($sformatf("vec%0d_adr", i), sdram.adr, tv[i].e_adr);
         check($sformatf("vec%0d_ack", i), {vga.ack, mire.ack}, {tv[i].e_vack, tv[i].e_mack});
      end

      // mire 16-beat incrementing burst, vga joins at beat 3 and must wait
      do_reset();
      mire.cyc = 1; mire.stb = 1; mire.cti = 3'b010; mire.adr = 32'h200;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         sdram.ack = 1;
         mire.cti = (b == 15) ? 3'b111 : 3'b010;
         mire.adr = 32'h200 + 4 * b;
         if (b == 3) begin vga.cyc = 1; vga.stb = 1; vga.adr = 32'h100; end
         #1;
         check($sformatf("burst%0d_ack", b), {vga.ack, mire.ack}, 2'b01);
         check($sformatf("burst%0d_adr", b), {sdram.cyc, sdram.cti, sdram.adr}, {1'b1, mire.cti, 32'h200 + 32'(4 * b)});
      end
      @(negedge clk);
      mire.cyc = 0; mire.stb = 0; sdram.ack = 0;
      #1 check("burst_release_cyc", sdram.cyc, 1'b0);
      @(negedge clk);
      #1 check("burst_handover", {sdram.cyc, sdram.adr}, {1'b1, 32'h100});

      // reset lands on beat 5 of a mire burst while vga waits
      do_reset();
      mire.cyc = 1; mire.stb = 1; mire.cti = 3'b010; mire.adr = 32'h200;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         sdram.ack = 1;
         vga.cyc = 1; vga.stb = 1; vga.adr = 32'h100;
      end
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_mid_burst", {sdram.cyc, sdram.stb, sdram.we, vga.ack, mire.ack}, 5'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_idle_after", sdram.cyc, 1'b0);
      @(negedge clk);
      #1 check("rst_tie_to_vga", {sdram.cyc, sdram.adr, vga.ack, mire.ack}, {1'b1, 32'h100, 2'b10});

      // slave error while vga owns the bus
      do_reset();
      vga.cyc = 1; vga.stb = 1; vga.adr = 32'h100;
      @(negedge clk);
      mire.cyc = 1; mire.stb = 1;
      sdram.err = 1; sdram.dat_sm = 32'hCAFEF00D;
      #1;
      check("err_route", {vga.err, mire.err, vga.ack, mire.ack}, 4'b1000);
      check("dat_sm_vga", vga.dat_sm, 32'hCAFEF00D);
      check("dat_sm_mire", mire.dat_sm, 32'hCAFEF00D);

      // randomized traffic against the ownership model
      do_reset();
      own = -1; last = 1;
      for (int i = 0; i < 2; i++) mcyc[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [127:0] exp_bus, act_bus;
         logic [2:0]   sresp;
         logic [31:0]  sdat;
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            mcyc[i] = mcyc[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            mstb[i] = 1'($urandom); mwe[i] = 1'($urandom);
            madr[i] = $urandom; mdat[i] = $urandom;
            msel[i] = 4'($urandom); mcti[i] = 3'($urandom); mbte[i] = 2'($urandom);
         end
         sresp = 3'($urandom); sdat = $urandom;
         vga.cyc = mcyc[0]; vga.stb = mstb[0]; vga.we = mwe[0]; vga.adr = madr[0];
         vga.dat_ms = mdat[0]; vga.sel = msel[0]; vga.cti = mcti[0]; vga.bte = mbte[0];
         mire.cyc = mcyc[1]; mire.stb = mstb[1]; mire.we = mwe[1]; mire.adr = madr[1];
         mire.dat_ms = mdat[1]; mire.sel = msel[1]; mire.cti = mcti[1]; mire.bte = mbte[1];
         {sdram.ack, sdram.err, sdram.rty} = sresp; sdram.dat_sm = sdat;
         if (rst) begin own = -1; last = 1; end
         #1;
         exp_bus = (own < 0) ? 128'h0 :
                   {mcyc[own], mstb[own], mwe[own], madr[own], mdat[own], msel[own], mcti[own], mbte[own]};
         act_bus = {sdram.cyc, sdram.stb, sdram.we, sdram.adr, sdram.dat_ms, sdram.sel, sdram.cti, sdram.bte};
         check("rnd_bus", act_bus, exp_bus);
         check("rnd_resp", {vga.ack, vga.err, vga.rty, mire.ack, mire.err, mire.rty},
               {(own == 0) ? sresp : 3'b0, (own == 1) ? sresp : 3'b0});
         check("rnd_dat_sm", {vga.dat_sm, mire.dat_sm}, {sdat, sdat});
         @(posedge clk);
         if (!rst) begin
            if (own < 0) begin
               if (mcyc[0] && mcyc[1]) own = 1 - last;
               else if (mcyc[0]) own = 0;
               else if (mcyc[1]) own = 1;
            end else if (!mcyc[own]) begin
               last = own;
               own = mcyc[1 - own] ? 1 - own : -1;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
